// File: rtl/ff_bank_scheduler_pkg.sv
// Shared constants for the JK bank scheduler: opcodes, FSM encoding, requester ids.
package ff_bank_scheduler_pkg;

   localparam logic [2:0] OP_HOLD   = 3'd0;
   localparam logic [2:0] OP_SET    = 3'd1;
   localparam logic [2:0] OP_CLEAR  = 3'd2;
   localparam logic [2:0] OP_TOGGLE = 3'd3;
   localparam logic [2:0] OP_LOAD   = 3'd4;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_APPLY = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   localparam logic ID_A = 1'b0;
   localparam logic ID_B = 1'b1;

   function automatic logic op_legal(input logic [2:0] op);
      return (op <= OP_LOAD);
   endfunction

endpackage

// File: rtl/ff_bank_scheduler_jk_bank.sv
// Bank of JK cells: 00 hold, 01 clear, 10 set, 11 toggle per bit.
module jk_bank #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else begin
         // Characteristic equation Q+ = J~Q | ~KQ applied bitwise.
         q <= (j & ~q) | (~k & q);
      end
   end

endmodule

// File: rtl/ff_bank_scheduler.sv
// Two-requester round-robin command scheduler driving a JK register bank.
//
// state   | meaning
// S_IDLE  | arbitrate, accept one command via valid/ready
// S_APPLY | drive J/K from the latched command for one clock
// S_RESP  | bank updated; done/done_id/err presented
module ff_bank_scheduler
   import ff_bank_scheduler_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [2:0]       a_op,
   input  logic [WIDTH-1:0] a_mask,
   input  logic [WIDTH-1:0] a_data,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [2:0]       b_op,
   input  logic [WIDTH-1:0] b_mask,
   input  logic [WIDTH-1:0] b_data,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic             err
);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             last;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] mask_r;
   logic [WIDTH-1:0] data_r;
   logic             id_r;

   logic             idle;
   logic             grant_a;
   logic             grant_b;
   logic             hs_a;
   logic             hs_b;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;

   assign idle = (state == S_IDLE);

   // On a tie the requester that did not win the previous handshake goes first.
   assign grant_a = a_valid && (!b_valid || (last == ID_B));
   assign grant_b = b_valid && (!a_valid || (last == ID_A));

   assign a_ready = idle && grant_a && !reset;
   assign b_ready = idle && grant_b && !reset;

   assign hs_a = a_valid && a_ready;
   assign hs_b = b_valid && b_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (hs_a || hs_b) state_nxt = S_APPLY;
         S_APPLY: state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         last   <= ID_B;
         op_r   <= OP_HOLD;
         mask_r <= '0;
         data_r <= '0;
         id_r   <= ID_A;
      end else begin
         state <= state_nxt;
         if (hs_a) begin
            last   <= ID_A;
            op_r   <= a_op;
            mask_r <= a_mask;
            data_r <= a_data;
            id_r   <= ID_A;
         end else if (hs_b) begin
            last   <= ID_B;
            op_r   <= b_op;
            mask_r <= b_mask;
            data_r <= b_data;
            id_r   <= ID_B;
         end
      end
   end

   always_comb begin
      j = '0;
      k = '0;
      if (state == S_APPLY) begin
         case (op_r)
            OP_SET: begin
               j = mask_r;
            end
            OP_CLEAR: begin
               k = mask_r;
            end
            OP_TOGGLE: begin
               j = mask_r;
               k = mask_r;
            end
            OP_LOAD: begin
               j = mask_r & data_r;
               k = mask_r & ~data_r;
            end
            default: begin
               j = '0;
               k = '0;
            end
         endcase
      end
   end

   jk_bank #(.WIDTH(WIDTH)) u_bank (
      .clk   (clk),
      .reset (reset),
      .j     (j),
      .k     (k),
      .q     (q)
   );

   // Status outputs derive from registered state and latched fields only.
   assign busy    = !idle && !reset;
   assign done    = (state == S_RESP) && !reset;
   assign done_id = done && id_r;
   assign err     = done && !op_legal(op_r);

endmodule

// File: tb/tb_ff_bank_scheduler.sv
// Directed bench for ff_bank_scheduler: vector table plus multi-cycle sequences.
module tb_ff_bank_scheduler;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             a_valid, b_valid;
   logic             a_ready, b_ready;
   logic [2:0]       a_op, b_op;
   logic [WIDTH-1:0] a_mask, a_data, b_mask, b_data;
   logic [WIDTH-1:0] q;
   logic             busy, done, done_id, err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit         req;
      logic [2:0] op;
      logic [7:0] mask;
      logic [7:0] data;
      logic [7:0] exp_q;
      bit         exp_err;
   } vec_t;

   vec_t vecs[11];

   ff_bank_scheduler #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .a_op    (a_op),
      .a_mask  (a_mask),
      .a_data  (a_data),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .b_op    (b_op),
      .b_mask  (b_mask),
      .b_data  (b_data),
      .q       (q),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .err     (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_one(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      @(negedge clk);
      if (v.req) begin
         b_valid = 1'b1; b_op = v.op; b_mask = v.mask; b_data = v.data;
      end else begin
         a_valid = 1'b1; a_op = v.op; a_mask = v.mask; a_data = v.data;
      end
      #1;
      check({tag, " a_ready"}, a_ready, !v.req);
      check({tag, " b_ready"}, b_ready, v.req);
      @(posedge clk); #1;
      a_valid = 1'b0; b_valid = 1'b0;
      check({tag, " apply busy"}, busy, 1);
      check({tag, " apply done"}, done, 0);
      @(posedge clk); #1;
      check({tag, " done"}, done, 1);
      check({tag, " done_id"}, done_id, v.req);
      check({tag, " err"}, err, v.exp_err);
      check({tag, " q"}, q, v.exp_q);
      @(posedge clk); #1;
      check({tag, " idle busy"}, busy, 0);
      check({tag, " idle done"}, done, 0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0] ids;
      int         n_done;
      int         hs_cnt;
      int         busy_cnt;
      int         prev_hs;
      bit         both_rdy;
      vec_t       v;

      vecs[0]  = '{1'b0, 3'd1, 8'h0F, 8'h00, 8'h0F, 1'b0};
      vecs[1]  = '{1'b1, 3'd4, 8'hF0, 8'hA5, 8'hAF, 1'b0};
      vecs[2]  = '{1'b1, 3'd3, 8'hFF, 8'h00, 8'h50, 1'b0};
      vecs[3]  = '{1'b1, 3'd2, 8'h50, 8'h00, 8'h00, 1'b0};
      vecs[4]  = '{1'b0, 3'd1, 8'h3C, 8'h00, 8'h3C, 1'b0};
      vecs[5]  = '{1'b0, 3'd6, 8'hFF, 8'hFF, 8'h3C, 1'b1};
      vecs[6]  = '{1'b0, 3'd0, 8'hFF, 8'hFF, 8'h3C, 1'b0};
      vecs[7]  = '{1'b1, 3'd4, 8'h0F, 8'h81, 8'h31, 1'b0};
      vecs[8]  = '{1'b0, 3'd3, 8'h03, 8'h00, 8'h32, 1'b0};
      vecs[9]  = '{1'b0, 3'd7, 8'hFF, 8'h00, 8'h32, 1'b1};
      vecs[10] = '{1'b1, 3'd5, 8'hFF, 8'hFF, 8'h32, 1'b1};

      reset = 1'b1;
      a_valid = 1'b1; a_op = 3'd1; a_mask = 8'hFF; a_data = 8'h00;
      b_valid = 1'b1; b_op = 3'd1; b_mask = 8'hFF; b_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("reset a_ready", a_ready, 0);
      check("reset b_ready", b_ready, 0);
      check("reset q", q, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset err", err, 0);
      check("reset done_id", done_id, 0);
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_one(vecs[i], i);
      end

      // Tie from reset: both held, expect A,B,A,B.
      pulse_reset();
      a_valid = 1'b1; a_op = 3'd1; a_mask = 8'h01; a_data = 8'h00;
      b_valid = 1'b1; b_op = 3'd1; b_mask = 8'h02; b_data = 8'h00;
      ids = '0; n_done = 0; both_rdy = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (a_ready && b_ready) both_rdy = 1;
         if (done) begin
            if (n_done < 4) ids[n_done] = done_id;
            n_done++;
         end
         @(negedge clk);
      end
      a_valid = 1'b0; b_valid = 1'b0;
      check("tie both ready", both_rdy, 0);
      check("tie done count", n_done, 4);
      check("tie done_id seq", ids, 4'b1010);
      #1;
      check("tie q", q, 8'h03);
      @(posedge clk); #1;

      // Make last=A, then reset mid-APPLY; tie afterwards must still go to A.
      v = '{1'b0, 3'd0, 8'h00, 8'h00, 8'h03, 1'b0};
      run_one(v, 100);
      @(negedge clk);
      a_valid = 1'b1; a_op = 3'd1; a_mask = 8'hFF; a_data = 8'h00;
      @(posedge clk); #1;
      a_valid = 1'b0;
      check("mid apply busy", busy, 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid reset busy", busy, 0);
      check("mid reset done", done, 0);
      @(posedge clk); #1;
      check("mid reset q", q, 0);
      check("mid reset busy2", busy, 0);
      @(negedge clk);
      reset = 1'b0;
      n_done = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (done) n_done++;
         @(negedge clk);
      end
      check("mid reset no done", n_done, 0);
      check("mid reset q after", q, 0);
      a_valid = 1'b1; a_op = 3'd1; a_mask = 8'h11; a_data = 8'h00;
      b_valid = 1'b1; b_op = 3'd1; b_mask = 8'h22; b_data = 8'h00;
      #1;
      check("post reset tie a_ready", a_ready, 1);
      check("post reset tie b_ready", b_ready, 0);
      @(posedge clk); #1;
      a_valid = 1'b0; b_valid = 1'b0;
      @(posedge clk); #1;
      check("post reset done", done, 1);
      check("post reset done_id", done_id, 0);
      check("post reset q", q, 8'h11);
      @(posedge clk); #1;

      // Back-to-back: A held valid, handshakes every 3 cycles.
      @(negedge clk);
      a_valid = 1'b1; a_op = 3'd0; a_mask = 8'h00; a_data = 8'h00;
      hs_cnt = 0; busy_cnt = 0; prev_hs = -1;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (busy) busy_cnt++;
         if (a_ready) begin
            if (prev_hs >= 0) check("b2b spacing", c - prev_hs, 3);
            prev_hs = c;
            hs_cnt++;
         end
         @(negedge clk);
      end
      a_valid = 1'b0;
      check("b2b handshakes", hs_cnt, 4);
      check("b2b busy cycles", busy_cnt, 8);
      check("b2b q", q, 8'h11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ff_bank_scheduler.md
# ff_bank_scheduler

A command scheduler for a WIDTH-bit register bank built from JK-style cells. It lets two independent requesters (A and B) share the bank through a valid/ready handshake with round-robin arbitration. Each accepted command is translated into per-bit J/K drives (hold, set, clear, toggle, load) and applied in one clock, then completion is signalled. It sits between control logic and the flip-flop storage, so requesters never drive J/K directly.

## Interface
Parameters:
- WIDTH, 8, number of bank bits (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk
- a_valid  in  1  requester A has a command
- a_ready  out  1  A's command accepted this cycle when a_valid&a_ready
- a_op  in  3  A opcode
- a_mask  in  WIDTH  A per-bit enable
- a_data  in  WIDTH  A load data (LOAD only)
- b_valid, b_ready, b_op, b_mask, b_data  same as A, for requester B
- q  out  WIDTH  current bank contents
- busy  out  1  high whenever the FSM is not IDLE
- done  out  1  one-cycle completion pulse
- done_id  out  1  requester of the completed command (0=A, 1=B); valid only with done
- err  out  1  with done: the completed opcode was illegal

## Operation
- Opcodes: 0 HOLD (j=k=0), 1 SET (j=mask, k=0), 2 CLEAR (j=0, k=mask), 3 TOGGLE (j=k=mask), 4 LOAD (j=mask&data, k=mask&~data), 5–7 illegal (j=k=0, err=1).
- Bits with mask=0 never change.
- FSM states and transitions:
  - IDLE → APPLY on handshake; latch op/mask/data/id.
  - APPLY → RESP unconditionally; J/K driven from latched command for exactly this cycle.
  - RESP → IDLE unconditionally; done=1, done_id, err asserted.
- Arbitration happens in IDLE only:
  - Exactly one valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - `last` updates on each handshake; reset value is B, so A wins the first tie.
- Ready rules:
  - x_ready = (state==IDLE) && grant_x. Ready depends combinationally on valid.
  - At most one ready is high per cycle; both are low outside IDLE.
- A requester holding valid while not granted is served in a later IDLE cycle. Its command inputs must remain stable until its handshake.
- Reset (any state, including mid-command):
  - state=IDLE, q=0, last=B.
  - done=0, err=0, busy=0, ready=0 in the reset cycle.
  - The in-flight command is discarded: no done, no bank change.

## Timing
- Handshake on edge T → APPLY during T+1 → q updated at edge T+2 → RESP (done high) during T+2 → IDLE during T+3.
- New handshake possible at the earliest at edge T+3; maximum throughput is one command per 3 cycles.
- q is a registered output. It reflects the command from the RESP cycle onward, so done and the new q are coincident.
- done/err/done_id are decoded from state and latched fields (registered-equivalent), with no combinational path from inputs.
- busy is high in APPLY and RESP.
- Reset values: q=0, busy=0, done=0, done_id=0, err=0, a_ready/b_ready=0 while reset is asserted.

## Structure
- Shared package: opcode constants (OP_HOLD..OP_LOAD), FSM state encoding (S_IDLE, S_APPLY, S_RESP), requester id constants (ID_A=0, ID_B=1).
- One sub-module, jk_bank:
  - WIDTH JK cells with synchronous active-high reset.
  - Inputs clk, reset, j[WIDTH], k[WIDTH]; output q[WIDTH].
  - 00 hold, 01 clear, 10 set, 11 toggle per bit.
- The top level holds the FSM, arbiter, command latch and J/K decode.

## Test plan
- Reset then A: SET mask=0x0F → a_ready=1 in handshake cycle; done=1, done_id=0, err=0 two cycles later; q=0x0F.
- From q=0x0F, B: LOAD mask=0xF0 data=0xA5 → q=0xAF; TOGGLE mask=0xFF → q=0x50; CLEAR mask=0x50 → q=0x00.
- A and B valid together from reset, both held → grants A, B, A, B; done_id sequence 0,1,0,1; never both ready in one cycle.
- A op=6 mask=0xFF with q=0x3C → done=1, err=1, q stays 0x3C; next HOLD → err=0, q unchanged.
- Reset asserted in APPLY of a SET 0xFF → no done pulse, q=0x00, busy=0 next cycle, first tie afterward goes to A.
- Back-to-back A valid held high → handshakes exactly 3 cycles apart; busy high for 2 of every 3 cycles.
